reg_xfer_ctrl: RTL and testbench

- Register-transfer sequencer for the 32-bit register bank datapath: 16 Register instances on a shared 32-bit bus, plus Y and Z registers around the ALU.
- Accepts one instruction (op, rd, rs, rt) through a start/ready handshake.
- Steps through T-states, driving one-hot register load enables (Rin) and bus-drive enables (Rout), Y/Z controls and the ALU operation.
- Sits between the instruction source (testbench now, fetch/decode unit later) and the register bank.

---
 rtl/reg_xfer_pkg.sv | 20 ++
 rtl/sel_decode.sv | 16 +
 rtl/reg_xfer_ctrl.sv | 99 +++++++++
 tb/tb_reg_xfer_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_xfer_pkg.sv
// Shared constants for the register-transfer sequencer: opcodes, FSM states, default sizes.
package reg_xfer_pkg;

  localparam int unsigned DEF_NREGS = 16;
  localparam int unsigned DEF_SEL_W = 4;
  localparam int unsigned DEF_OP_W  = 2;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_e;

endpackage

// File: rtl/sel_decode.sv
// Register-select to one-hot enable decoder; all zeros when en is low.
module sel_decode #(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned NREGS = 16
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [NREGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// T-state sequencer driving register bank load/drive enables and Y/Z/ALU controls.
module reg_xfer_ctrl
  import reg_xfer_pkg::*;
#(
  parameter int unsigned NREGS = DEF_NREGS,
  parameter int unsigned SEL_W = DEF_SEL_W,
  parameter int unsigned OP_W  = DEF_OP_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [SEL_W-1:0] rd,
  input  logic [SEL_W-1:0] rs,
  input  logic [SEL_W-1:0] rt,
  output logic             ready,
  output logic [NREGS-1:0] rin,
  output logic [NREGS-1:0] rout,
  output logic             y_in,
  output logic             z_in,
  output logic             z_out,
  output logic             zero_out,
  output logic             alu_sub,
  output logic             done
);

  if (NREGS != (1 << SEL_W)) begin : g_cfg_check
    $error("reg_xfer_ctrl: NREGS must equal 2**SEL_W");
  end

  state_e           state_q;
  logic [OP_W-1:0]  op_q;
  logic [SEL_W-1:0] rd_q, rs_q, rt_q;

  logic             is_alu;
  logic             rin_en, rout_en;
  logic [SEL_W-1:0] rout_sel;

  assign is_alu = (op_q == OP_ADD) || (op_q == OP_SUB);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            rd_q    <= rd;
            rs_q    <= rs;
            rt_q    <= rt;
            state_q <= S_T1;
          end
        end
        S_T1:    state_q <= is_alu ? S_T2 : S_IDLE;
        S_T2:    state_q <= S_T3;
        S_T3:    state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Moore decode; only ALU ops ever reach T2/T3.
  always_comb begin
    ready    = (state_q == S_IDLE);
    y_in     = (state_q == S_T1) && is_alu;
    z_in     = (state_q == S_T2);
    alu_sub  = (state_q == S_T2) && (op_q == OP_SUB);
    z_out    = (state_q == S_T3);
    zero_out = (state_q == S_T1) && (op_q == OP_CLR);
    done     = ((state_q == S_T1) && !is_alu) || (state_q == S_T3);
    rin_en   = done;
    rout_en  = ((state_q == S_T1) && (op_q != OP_CLR)) || (state_q == S_T2);
    rout_sel = (state_q == S_T2) ? rt_q : rs_q;
  end

  sel_decode #(
    .SEL_W (SEL_W),
    .NREGS (NREGS)
  ) u_rin_dec (
    .sel    (rd_q),
    .en     (rin_en),
    .onehot (rin)
  );

  sel_decode #(
    .SEL_W (SEL_W),
    .NREGS (NREGS)
  ) u_rout_dec (
    .sel    (rout_sel),
    .en     (rout_en),
    .onehot (rout)
  );

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Bench for reg_xfer_ctrl: a behavioural register bank plus an instruction-level reference model.
module tb_reg_xfer_ctrl;
  import reg_xfer_pkg::*;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [3:0]  rd = '0, rs = '0, rt = '0;
  logic        ready, y_in, z_in, z_out, zero_out, alu_sub, done;
  logic [15:0] rin, rout;
  logic [38:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_xfer_ctrl dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .op       (op),
    .rd       (rd),
    .rs       (rs),
    .rt       (rt),
    .ready    (ready),
    .rin      (rin),
    .rout     (rout),
    .y_in     (y_in),
    .z_in     (z_in),
    .z_out    (z_out),
    .zero_out (zero_out),
    .alu_sub  (alu_sub),
    .done     (done)
  );

  assign obs = {ready, rin, rout, y_in, z_in, z_out, zero_out, alu_sub, done};

  // Behavioural datapath: 16 registers, Y, Z, shared bus, plus a preload port for the bench.
  logic [31:0] bank [16];
  logic [31:0] y_q = '0, z_q = '0, bus;
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  always_comb begin
    bus = '0;
    for (int i = 0; i < 16; i++) if (rout[i]) bus |= bank[i];
    if (z_out) bus |= z_q;
  end

  always @(posedge clk) begin
    if (y_in) y_q <= bus;
    if (z_in) z_q <= alu_sub ? (y_q - bus) : (y_q + bus);
    for (int i = 0; i < 16; i++) if (rin[i]) bank[i] <= bus;
    if (pl_en) bank[pl_idx] <= pl_val;
  end

  logic [31:0] model [16];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected control word for transfer step k of an instruction; k < 0 means idle.
  function automatic logic [38:0] exp_out(input int k, input logic [1:0] o,
                                          input logic [3:0] d, input logic [3:0] s,
                                          input logic [3:0] t);
    logic        rdy, yi, zi, zo, zr, sb, dn;
    logic [15:0] ri, ro;
    rdy = (k < 0);
    {yi, zi, zo, zr, sb, dn} = '0;
    ri = '0;
    ro = '0;
    if (k >= 0) begin
      if (o == OP_MOV) begin
        ro = 16'(1) << s; ri = 16'(1) << d; dn = 1'b1;
      end else if (o == OP_CLR) begin
        zr = 1'b1; ri = 16'(1) << d; dn = 1'b1;
      end else if (k == 0) begin
        ro = 16'(1) << s; yi = 1'b1;
      end else if (k == 1) begin
        ro = 16'(1) << t; zi = 1'b1; sb = (o == OP_SUB);
      end else begin
        zo = 1'b1; ri = 16'(1) << d; dn = 1'b1;
      end
    end
    return {rdy, ri, ro, yi, zi, zo, zr, sb, dn};
  endfunction

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
    model[idx] = val;
  endtask

  // Issue one instruction from an idle cycle; optionally keep start high with MOV fields while busy.
  task automatic run_instr(input logic [1:0] o, input logic [3:0] d, input logic [3:0] s,
                           input logic [3:0] t, input bit hammer);
    logic [31:0] res;
    int          n;
    case (o)
      OP_MOV:  res = model[s];
      OP_ADD:  res = model[s] + model[t];
      OP_SUB:  res = model[s] - model[t];
      default: res = '0;
    endcase
    n = (o == OP_ADD || o == OP_SUB) ? 3 : 1;
    start = 1'b1; op = o; rd = d; rs = s; rt = t;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      start = hammer;
      if (hammer) begin
        op = OP_MOV; rd = 4'($urandom_range(15)); rs = 4'($urandom_range(15));
      end
      @(negedge clk);
      check_eq($sformatf("step%0d_op%0d", k, o), 64'(obs), 64'(exp_out(k, o, d, s, t)));
      @(posedge clk); #1;
    end
    start = 1'b0;
    model[d] = res;
    @(negedge clk);
    check_eq($sformatf("idle_after_op%0d", o), 64'(obs), 64'(exp_out(-1, o, d, s, t)));
    check_eq($sformatf("r%0d_after_op%0d", d, o), 64'(bank[d]), 64'(res));
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < 16; i++)
      check_eq($sformatf("%s_r%0d", tag, i), 64'(bank[i]), 64'(model[i]));
  endtask

  initial begin
    logic [38:0] idle_w;
    idle_w = exp_out(-1, OP_MOV, 4'd0, 4'd0, 4'd0);

    // Reset held for two cycles, outputs idle during and after.
    @(negedge clk);
    check_eq("reset_during", 64'(obs), 64'(idle_w));
    @(posedge clk); @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check_eq("reset_after", 64'(obs), 64'(idle_w));

    for (int i = 0; i < 16; i++) preload(4'(i), $urandom);

    preload(4'd5, 32'hDEADBEEF);
    run_instr(OP_MOV, 4'd3, 4'd5, 4'd0, 1'b0);
    check_eq("mov_r3", 64'(bank[3]), 64'h0000_0000_DEAD_BEEF);

    preload(4'd2, 32'd7);
    preload(4'd4, 32'd9);
    run_instr(OP_ADD, 4'd1, 4'd2, 4'd4, 1'b0);
    check_eq("add_r1", 64'(bank[1]), 64'd16);
    run_instr(OP_SUB, 4'd1, 4'd2, 4'd4, 1'b0);
    check_eq("sub_r1", 64'(bank[1]), 64'h0000_0000_FFFF_FFFE);

    preload(4'd15, 32'hFFFF_FFFF);
    run_instr(OP_CLR, 4'd15, 4'd0, 4'd0, 1'b0);
    check_eq("clr_r15", 64'(bank[15]), 64'd0);

    // Start pulses during T1, T2 and the done cycle must be ignored.
    run_instr(OP_ADD, 4'd6, 4'd2, 4'd4, 1'b1);
    check_bank("busy");

    // clr during T2: enables drop at once, no done, destination untouched.
    @(negedge clk);
    start = 1'b1; op = OP_ADD; rd = 4'd7; rs = 4'd2; rt = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    clr = 1'b1;
    #1;
    check_eq("clr_immediate", 64'(obs), 64'(idle_w));
    @(posedge clk); #1;
    clr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq($sformatf("clr_idle%0d", c), 64'(obs), 64'(idle_w));
    end
    check_eq("clr_r7_kept", 64'(bank[7]), 64'(model[7]));
    run_instr(OP_MOV, 4'd8, 4'd5, 4'd0, 1'b0);

    // Random instruction stream, including aliased operands and busy-time start pulses.
    for (int n = 0; n < 60; n++) begin
      run_instr(2'($urandom_range(3)), 4'($urandom_range(15)), 4'($urandom_range(15)),
                4'($urandom_range(15)), bit'($urandom_range(1)));
    end
    check_bank("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
